// File: rtl/loop_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : loop_seq_pkg
//  Purpose  : Shared defaults, loop frame layout and next-state action codes
//             for the zero-overhead loop sequencer.
//  Contents : PC_W_DEF / CNT_W_DEF / DEPTH_DEF  default widths and depth
//             loop_frame_t                      frame layout at default widths
//             seq_act_t                         per-edge action selected
//  Revision : 1.0  initial release
// ============================================================================
package loop_seq_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // One loop frame. "end" is a reserved word, hence the _pc suffixes.
  typedef struct packed {
    logic [PC_W_DEF-1:0]  start_pc;
    logic [PC_W_DEF-1:0]  end_pc;
    logic [CNT_W_DEF-1:0] reps;
    logic [CNT_W_DEF-1:0] iter;
  } loop_frame_t;

  // What the sequencer does on the coming clock edge.
  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,  // stalled
    ACT_BRANCH = 3'd1,  // jump, flush all frames
    ACT_PUSH   = 3'd2,  // accepted loop instruction
    ACT_SKIP   = 3'd3,  // zero-length or zero-rep loop, jump over body
    ACT_REJECT = 3'd4,  // illegal loop, jump over body and flag error
    ACT_REPEAT = 3'd5,  // end of body, more iterations to go
    ACT_POP    = 3'd6,  // end of body, last iteration done
    ACT_STEP   = 3'd7   // plain pc+1
  } seq_act_t;

endpackage : loop_seq_pkg
`default_nettype wire

// File: rtl/loop_stack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : loop_stack
//  Purpose  : LIFO of loop frames with push, pop, top-iteration update and
//             flush. Only one operation is requested per cycle by the owner.
//  Ports    : clk, rst (async, active low)
//             flush/pop/push/upd       operation strobes (flush wins)
//             push_start/end/reps      new frame fields (iter starts at 0)
//             upd_iter                 replacement iteration count of top
//             top_start/end/reps/iter  top frame fields, 0 when empty
//             depth, full, empty       occupancy
//  Revision : 1.0  initial release
// ============================================================================
module loop_stack
  import loop_seq_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       pop,
  input  logic                       push,
  input  logic                       upd,
  input  logic [PC_W-1:0]            push_start,
  input  logic [PC_W-1:0]            push_end,
  input  logic [CNT_W-1:0]           push_reps,
  input  logic [CNT_W-1:0]           upd_iter,
  output logic [PC_W-1:0]            top_start,
  output logic [PC_W-1:0]            top_end,
  output logic [CNT_W-1:0]           top_reps,
  output logic [CNT_W-1:0]           top_iter,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DW = $clog2(DEPTH + 1);
  // Index width kept at least 1 so DEPTH=1 still has a legal vector.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  r_start [DEPTH];
  logic [PC_W-1:0]  r_end   [DEPTH];
  logic [CNT_W-1:0] r_reps  [DEPTH];
  logic [CNT_W-1:0] r_iter  [DEPTH];
  logic [DW-1:0]    r_count;

  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_push_idx;

  assign w_top_idx  = IW'(r_count - 1'b1);
  assign w_push_idx = IW'(r_count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_reps[i]  <= '0;
        r_iter[i]  <= '0;
      end
    end else if (flush) begin
      r_count <= '0;
    end else if (pop) begin
      r_count <= r_count - 1'b1;
    end else if (push) begin
      r_start[w_push_idx] <= push_start;
      r_end[w_push_idx]   <= push_end;
      r_reps[w_push_idx]  <= push_reps;
      r_iter[w_push_idx]  <= '0;
      r_count             <= r_count + 1'b1;
    end else if (upd) begin
      r_iter[w_top_idx] <= upd_iter;
    end
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == DW'(DEPTH));
  assign depth = r_count;

  // Stale slots are masked so an empty stack reads as all-zero.
  assign top_start = empty ? '0 : r_start[w_top_idx];
  assign top_end   = empty ? '0 : r_end[w_top_idx];
  assign top_reps  = empty ? '0 : r_reps[w_top_idx];
  assign top_iter  = empty ? '0 : r_iter[w_top_idx];

endmodule : loop_stack
`default_nettype wire

// File: rtl/loop_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : loop_sequencer
//  Purpose  : Program counter with hardware nested loops. A loop instruction
//             pushes a frame; when pc reaches the top frame's end the body is
//             repeated or the frame is popped.
//  Ports    : clk, rst (async, active low)
//             stall_en                 freeze everything this cycle
//             branch_en/target_address jump and flush all frames
//             loop_en/line_count/rep_count  loop instruction at current pc
//             pc, loop_depth, iter     current state (iter of top frame)
//             loop_done                pulse after a frame pops
//             loop_err                 sticky illegal-loop flag
//  Revision : 1.0  initial release
// ============================================================================
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_en,
  input  logic                       branch_en,
  input  logic [PC_W-1:0]            target_address,
  input  logic                       loop_en,
  input  logic [CNT_W-1:0]           line_count,
  input  logic [CNT_W-1:0]           rep_count,
  output logic [PC_W-1:0]            pc,
  output logic [$clog2(DEPTH+1)-1:0] loop_depth,
  output logic [CNT_W-1:0]           iter,
  output logic                       loop_done,
  output logic                       loop_err
);

  // Wide enough to hold pc+line_count without wrapping, so overflow past the
  // top of the address space is visible.
  localparam int SW = ((PC_W > CNT_W) ? PC_W : CNT_W) + 1;

  logic [PC_W-1:0]  r_pc;
  logic             r_done;
  logic             r_err;

  logic [PC_W-1:0]  w_top_start;
  logic [PC_W-1:0]  w_top_end;
  logic [CNT_W-1:0] w_top_reps;
  logic [CNT_W-1:0] w_top_iter;
  logic             w_full;
  logic             w_empty;

  logic [SW-1:0]    w_end_ext;
  logic             w_overflow;
  logic             w_zero_loop;
  logic             w_nest_bad;
  logic             w_at_end;
  logic [CNT_W:0]   w_iter_next;
  logic             w_more;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_skip;
  seq_act_t         w_act;

  assign w_end_ext   = SW'(r_pc) + SW'(line_count);
  assign w_overflow  = |(w_end_ext >> PC_W);
  assign w_zero_loop = (line_count == '0) || (rep_count == '0);
  // An inner body must end strictly before the enclosing one, otherwise the
  // outer end would never be seen while the inner frame sits on top.
  assign w_nest_bad  = !w_empty && (w_end_ext >= SW'(w_top_end));
  assign w_at_end    = !w_empty && (r_pc == w_top_end);
  assign w_iter_next = {1'b0, w_top_iter} + 1'b1;
  assign w_more      = (w_iter_next < {1'b0, w_top_reps});
  assign w_pc_inc    = r_pc + 1'b1;
  assign w_pc_skip   = PC_W'(w_end_ext + 1'b1);

  always_comb begin
    w_act = ACT_STEP;
    if (stall_en) begin
      w_act = ACT_HOLD;
    end else if (branch_en) begin
      w_act = ACT_BRANCH;
    end else if (loop_en) begin
      if (w_zero_loop)
        w_act = ACT_SKIP;
      else if (w_full || w_overflow || w_nest_bad)
        w_act = ACT_REJECT;
      else
        w_act = ACT_PUSH;
    end else if (w_at_end) begin
      w_act = w_more ? ACT_REPEAT : ACT_POP;
    end
  end

  loop_stack #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk        (clk),
    .rst        (rst),
    .flush      (w_act == ACT_BRANCH),
    .pop        (w_act == ACT_POP),
    .push       (w_act == ACT_PUSH),
    .upd        (w_act == ACT_REPEAT),
    .push_start (w_pc_inc),
    .push_end   (w_end_ext[PC_W-1:0]),
    .push_reps  (rep_count),
    .upd_iter   (w_iter_next[CNT_W-1:0]),
    .top_start  (w_top_start),
    .top_end    (w_top_end),
    .top_reps   (w_top_reps),
    .top_iter   (w_top_iter),
    .depth      (loop_depth),
    .full       (w_full),
    .empty      (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (w_act)
        ACT_HOLD:   r_pc <= r_pc;
        ACT_BRANCH: r_pc <= target_address;
        ACT_PUSH:   r_pc <= w_pc_inc;
        ACT_SKIP:   r_pc <= w_pc_skip;
        ACT_REJECT: begin
          r_pc  <= w_pc_skip;
          r_err <= 1'b1;
        end
        ACT_REPEAT: r_pc <= w_top_start;
        ACT_POP: begin
          r_pc   <= w_top_end + 1'b1;
          r_done <= 1'b1;
        end
        default:    r_pc <= w_pc_inc;
      endcase
    end
  end

  assign pc        = r_pc;
  assign iter      = w_top_iter;
  assign loop_done = r_done;
  assign loop_err  = r_err;

endmodule : loop_sequencer
`default_nettype wire

// File: doc/loop_sequencer.md
LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 Parameter PC_W, default 8: width of program counter and addresses.
REQ-002 Parameter CNT_W, default 8: width of line and repetition counts.
REQ-003 Parameter DEPTH, default 4: maximum nested loop frames, at least 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 stall_en  input  1  freeze all state this cycle.
REQ-007 branch_en  input  1  jump to target_address and flush loop stack.
REQ-008 target_address  input  PC_W  branch destination.
REQ-009 loop_en  input  1  current pc holds a loop instruction.
REQ-010 line_count  input  CNT_W  body length in instructions, sampled with loop_en.
REQ-011 rep_count  input  CNT_W  body iteration count, sampled with loop_en.
REQ-012 pc  output  PC_W  current instruction address.
REQ-013 loop_depth  output  $clog2(DEPTH+1)  number of live frames.
REQ-014 iter  output  CNT_W  completed iterations of top frame; 0 when stack empty.
REQ-015 loop_done  output  1  one-cycle pulse on the cycle after a frame pops.
REQ-016 loop_err  output  1  sticky error flag.

Function
REQ-017 Priority per edge: stall_en > branch_en > loop_en > end-of-body > pc+1.
REQ-018 stall_en=1: pc, stack, iter, loop_err hold; loop_done is 0.
REQ-019 branch_en: pc<=target_address; stack empties; loop_depth<=0.
REQ-020 Plain step: pc<=pc+1, modulo 2^PC_W.
REQ-021 loop_en: frame {start=pc+1, end=pc+line_count, reps=rep_count, iter=0} is pushed; pc<=pc+1.
REQ-022 loop_en with line_count=0 or rep_count=0: no push; pc<=pc+1+line_count (loop skipped).
REQ-023 Push rejected and loop_err<=1 when: stack full; pc+line_count exceeds 2^PC_W-1; or stack non-empty and new end >= top frame end.
REQ-024 On rejected push, pc<=pc+1+line_count (body skipped).
REQ-025 End-of-body: stack non-empty and pc==top.end.
REQ-026 At end-of-body with top.iter+1 < top.reps: pc<=top.start; top.iter increments.
REQ-027 At end-of-body with top.iter+1 >= top.reps: frame pops; pc<=top.end+1; loop_done=1 on the following cycle.
REQ-028 Only the top frame is compared against pc; outer frames wait for the inner end, which REQ-023 keeps strictly below theirs.
REQ-029 rep_count=1: body runs once, then pops.
REQ-030 branch_en and loop_en together: the branch wins; no push; loop_err unchanged.
REQ-031 loop_err clears only on reset.

Reset
REQ-032 While rst=0: pc=0, stack empty, loop_depth=0, iter=0, loop_done=0, loop_err=0, asynchronously.
REQ-033 Reset during a loop discards all frames; first edge after release steps pc to 1.

Structure
REQ-034 Package loop_seq_pkg holds default PC_W, CNT_W, DEPTH and typedef loop_frame_t {start, end, reps, iter}.
REQ-035 Sub-module loop_stack holds the frames as a LIFO with push, pop, top-update and flush, and reports full/empty.
REQ-036 All next-state decode lives in loop_sequencer.

Verification
REQ-037 Reset, then 5 free cycles -> pc 0,1,2,3,4,5; loop_depth 0.
REQ-038 pc=2, loop_en, line_count=3, rep_count=2 -> pc 3,4,5,3,4,5,6; loop_done pulses with pc=6.
REQ-039 Nested case -> pc sequence 1,2,3,2,3,4,1,2,3,2,3,4,5 with loop_depth peaking at 2.
- Stimulus: pc=0, loop_en, line_count=4, rep_count=2.
- Stimulus: at pc=1, loop_en, line_count=2, rep_count=2.
REQ-040 DEPTH=1 bench with a second loop_en inside the body -> loop_err=1; inner body skipped; outer loop completes normally.
REQ-041 Mid-loop branch_en, target_address=9 -> pc=9; loop_depth=0 next cycle; stall_en held 3 cycles beforehand keeps pc and iter frozen.
REQ-042 rep_count=0 at pc=4, line_count=2 -> pc=7; no push; loop_err=0.
